// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down modulo counter with clear, load, saturate and wrap pulse
module updown_counter #(
    parameter int N   = 4,
    parameter int M   = 2**N-1,
    parameter bit SAT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         ld,
    input  logic [N-1:0] D,
    input  logic         E,
    input  logic         up,
    output logic [N-1:0] C,
    output logic         T,
    output logic         W,
    output logic         S
);
    localparam logic [N-1:0] MAX = N'(M);
    logic [N-1:0] r_c;
    logic         r_w;
    logic [N-1:0] w_nxt;
    logic         w_wrap;
    assign C = r_c;
    assign W = r_w;
    assign T = up ? (r_c == MAX) : (r_c == '0);
    assign S = SAT & E & T;
    // next count by priority clr > ld > E; wrap is explicit at the terminal value
    always_comb begin
        w_nxt  = r_c;
        w_wrap = 1'b0;
        if (clr)
            w_nxt = '0;
        else if (ld)
            w_nxt = (D > MAX) ? MAX : D;
        else if (E) begin
            if (!T)
                w_nxt = up ? r_c + 1'b1 : r_c - 1'b1;
            else if (!SAT) begin
                w_nxt  = up ? '0 : MAX;
                w_wrap = 1'b1;
            end
        end
    end
    // count and wrap-pulse registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_c <= '0;
            r_w <= 1'b0;
        end else begin
            r_c <= w_nxt;
            r_w <= w_wrap;
        end
    end
endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: three counter configurations checked against an arithmetic reference model
module tb_updown_counter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       ld  = 1'b0;
    logic       E   = 1'b0;
    logic       up  = 1'b1;
    logic [3:0] D   = '0;
    logic [3:0] c0, c1;
    logic       c2;
    logic       t0, t1, t2, w0, w1, w2, s0, s1, s2;
    int vectors = 0;
    int miscompares = 0;
    int mc[3];
    int mw[3];
    int mm[3] = '{9, 9, 1};
    int ms[3] = '{0, 1, 0};

    always #5 clk = ~clk;

    updown_counter #(.N(4), .M(9), .SAT(1'b0)) u0 (.clk(clk), .rst(rst), .clr(clr), .ld(ld), .D(D),
        .E(E), .up(up), .C(c0), .T(t0), .W(w0), .S(s0));
    updown_counter #(.N(4), .M(9), .SAT(1'b1)) u1 (.clk(clk), .rst(rst), .clr(clr), .ld(ld), .D(D),
        .E(E), .up(up), .C(c1), .T(t1), .W(w1), .S(s1));
    updown_counter #(.N(1), .M(1), .SAT(1'b0)) u2 (.clk(clk), .rst(rst), .clr(clr), .ld(ld), .D(D[0]),
        .E(E), .up(up), .C(c2), .T(t2), .W(w2), .S(s2));

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            mw[i] = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 3; i++) begin
            int d;
            int lim;
            d = (i == 2) ? int'(D[0]) : int'(D);
            lim = up ? mm[i] : 0;
            mw[i] = 0;
            if (rst || clr)
                mc[i] = 0;
            else if (ld)
                mc[i] = (d > mm[i]) ? mm[i] : d;
            else if (E) begin
                if (mc[i] != lim)
                    mc[i] = up ? mc[i] + 1 : mc[i] - 1;
                else if (ms[i] == 0) begin
                    mc[i] = up ? 0 : mm[i];
                    mw[i] = 1;
                end
            end
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int et;
            int gc, gt, gw, gs;
            et = up ? int'(mc[i] == mm[i]) : int'(mc[i] == 0);
            gc = (i == 0) ? int'(c0) : (i == 1) ? int'(c1) : int'(c2);
            gt = (i == 0) ? int'(t0) : (i == 1) ? int'(t1) : int'(t2);
            gw = (i == 0) ? int'(w0) : (i == 1) ? int'(w1) : int'(w2);
            gs = (i == 0) ? int'(s0) : (i == 1) ? int'(s1) : int'(s2);
            chk($sformatf("C%0d", i), gc, mc[i]);
            chk($sformatf("T%0d", i), gt, et);
            chk($sformatf("W%0d", i), gw, mw[i]);
            chk($sformatf("S%0d", i), gs, ms[i] * int'(E) * et);
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        rst = 1'b0;
        E = 1'b1;
        up = 1'b1;
        repeat (12) cyc();
        chk("up12_c", c0, 2);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        up = 1'b0;
        cyc();
        chk("dn_wrap_w", w0, 1);
        chk("dn_sat_s", s1, 1);
        repeat (2) cyc();
        chk("dn3_c", c0, 7);
        ld = 1'b1;
        D = 4'd9;
        cyc();
        ld = 1'b0;
        up = 1'b1;
        repeat (3) cyc();
        chk("sat_hold_c", c1, 9);
        chk("sat_w", w1, 0);
        up = 1'b0;
        #1;
        chk("sat_dir_t", t1, 0);
        cyc();
        chk("sat_dn_c", c1, 8);
        ld = 1'b1;
        D = 4'd5;
        up = 1'b1;
        cyc();
        chk("ld5_c", c0, 5);
        D = 4'd14;
        cyc();
        chk("ld_clamp_c", c0, 9);
        clr = 1'b1;
        D = 4'd3;
        cyc();
        chk("clr_ld_c", c0, 0);
        clr = 1'b0;
        D = 4'd7;
        cyc();
        ld = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("arst_c", c0, 0);
        #2;
        rst = 1'b0;
        cyc();
        chk("post_rst_c", c0, 1);
        repeat (400) begin
            rst = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 15) == 0);
            ld = ($urandom_range(0, 7) == 0);
            E = ($urandom_range(0, 3) != 0);
            up = ($urandom_range(0, 3) != 0);
            D = 4'($urandom_range(0, 15));
            if (rst)
                model_reset();
            #2;
            check_all();
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
